// File: rtl/bcd_timer.sv
// bcd_timer: BCD stopwatch/timer with run/pause/clear control
// and a multiplexed seven-segment scan driver on one clock.
module bcd_timer #(
  parameter int DIGITS      = 4,
  parameter int LOAD_DIGITS = 2,
  parameter int TICK_DIV    = 1_000_000,
  parameter int REFRESH_DIV = 100_000,
  parameter int DP_POS      = 2
) (
  input  logic                     c_clk,
  input  logic                     R_n,
  input  logic                     R,
  input  logic                     P,
  input  logic [1:0]               mode,
  input  logic [4*LOAD_DIGITS-1:0] load,
  output logic [4*DIGITS-1:0]      count,
  output logic [1:0]               state,
  output logic                     done,
  output logic [DIGITS-1:0]        an,
  output logic [6:0]               sseg,
  output logic                     dp
);

  localparam int CW = 4 * DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    S_CLEAR = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } st_t;

  st_t           st_q;
  logic          dir_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] presc_q;
  logic [RW-1:0] ref_q;
  logic [IW-1:0] idx_q;

  logic [CW-1:0] pre;
  logic [CW-1:0] nxt;
  logic          pre_term;
  logic          nxt_term;
  logic          tick;
  logic [3:0]    digit;

  function automatic logic [CW-1:0] all9();
    logic [CW-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'd9;
    return v;
  endfunction

  function automatic logic [CW-1:0] preset(
    input logic [1:0]               m,
    input logic [4*LOAD_DIGITS-1:0] ld
  );
    logic [CW-1:0] v;
    logic [3:0]    d;
    v = (m == 2'b10) ? all9() : '0;
    if (m[0]) begin
      for (int j = 0; j < LOAD_DIGITS; j++) begin
        d = ld[4*j +: 4];
        if (d > 4'd9) d = 4'd9;
        v[4*(DIGITS-LOAD_DIGITS+j) +: 4] = d;
      end
    end
    return v;
  endfunction

  // Ripple BCD: up wraps 9->0 with carry, down wraps 0->9 with borrow
  function automatic logic [CW-1:0] step(
    input logic [CW-1:0] v,
    input logic          dn
  );
    logic [CW-1:0] r;
    logic [3:0]    d;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (dn) begin
          if (d == 4'd0) d = 4'd9;
          else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d >= 4'd9) d = 4'd0;
          else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic is_term(
    input logic [CW-1:0] v,
    input logic          dn
  );
    return dn ? (v == '0) : (v == all9());
  endfunction

  assign pre      = preset(mode, load);
  assign pre_term = is_term(pre, mode[1]);
  assign nxt      = step(cnt_q, dir_q);
  assign nxt_term = is_term(nxt, dir_q);
  assign tick     = (st_q == S_RUN) &&
                    (presc_q == TW'(TICK_DIV - 1));

  // Control FSM, prescaler and count register
  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      st_q    <= S_CLEAR;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      presc_q <= '0;
    end else begin
      unique case (st_q)
        S_CLEAR: begin
          cnt_q   <= pre;
          presc_q <= '0;
          if (P && !R) begin
            dir_q <= mode[1];
            st_q  <= pre_term ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (R) begin
            st_q    <= S_CLEAR;
            cnt_q   <= pre;
            presc_q <= '0;
          end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) cnt_q <= nxt;
            if (P) st_q <= S_PAUSE;
            else if (tick && nxt_term) st_q <= S_DONE;
          end
        end
        S_PAUSE: begin
          if (R) begin
            st_q    <= S_CLEAR;
            cnt_q   <= pre;
            presc_q <= '0;
          end else if (P) begin
            st_q <= S_RUN;
          end
        end
        S_DONE: begin
          presc_q <= '0;
          if (R) begin
            st_q  <= S_CLEAR;
            cnt_q <= pre;
          end
        end
        default: st_q <= S_CLEAR;
      endcase
    end
  end

  // Free-running scan: advance digit index every REFRESH_DIV cycles
  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      ref_q <= '0;
      idx_q <= '0;
    end else if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_q <= '0;
      idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  // Select the scanned digit and decode it to active-low segments
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) digit = cnt_q[4*i +: 4];
    end
    case (digit)
      4'h0:    sseg = 7'b1000000;
      4'h1:    sseg = 7'b1111001;
      4'h2:    sseg = 7'b0100100;
      4'h3:    sseg = 7'b0110000;
      4'h4:    sseg = 7'b0011001;
      4'h5:    sseg = 7'b0010010;
      4'h6:    sseg = 7'b0000010;
      4'h7:    sseg = 7'b1111000;
      4'h8:    sseg = 7'b0000000;
      4'h9:    sseg = 7'b0010000;
      4'hA:    sseg = 7'b0001000;
      4'hB:    sseg = 7'b0000011;
      4'hC:    sseg = 7'b1000110;
      4'hD:    sseg = 7'b0100001;
      4'hE:    sseg = 7'b0000110;
      default: sseg = 7'b0001110;
    endcase
  end

  assign an    = DIGITS'(1) << idx_q;
  assign dp    = (int'(idx_q) != DP_POS);
  assign count = cnt_q;
  assign state = st_q;
  assign done  = (st_q == S_DONE);

endmodule
